// File: rtl/wb_master_arbiter_if.sv
// Shared Wishbone master-side pins: the arbiter drives the *_O group and samples the *_I group.
interface wb_master_arbiter_if;
  logic [63:0] ADR_O;
  logic [63:0] DAT_O;
  logic [7:0]  SEL_O;
  logic [15:0] TGA_O;
  logic [15:0] TGC_O;
  logic [15:0] TGD_O;
  logic        CYC_O;
  logic        STB_O;
  logic        WE_O;
  logic        LOCK_O;
  logic [63:0] DAT_I;
  logic [15:0] TGD_I;
  logic        ACK_I;
  logic        ERR_I;
  logic        RTY_I;

  modport master (
    output ADR_O, DAT_O, SEL_O, TGA_O, TGC_O, TGD_O, CYC_O, STB_O, WE_O, LOCK_O,
    input  DAT_I, TGD_I, ACK_I, ERR_I, RTY_I
  );

  modport slave (
    input  ADR_O, DAT_O, SEL_O, TGA_O, TGC_O, TGD_O, CYC_O, STB_O, WE_O, LOCK_O,
    output DAT_I, TGD_I, ACK_I, ERR_I, RTY_I
  );
endinterface

// File: rtl/wb_master_arbiter.sv
// Round-robin, CYC-framed arbiter sharing one Wishbone master port; grant registered (1 cycle),
// responses routed combinationally; a stalled STB is terminated with ERR after TIMEOUT cycles.
module wb_master_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                    clk,
  input  logic                    RST_I,
  input  logic [NUM_REQ-1:0]      req_cyc,
  input  logic [NUM_REQ-1:0]      req_stb,
  input  logic [NUM_REQ-1:0]      req_we,
  input  logic [NUM_REQ-1:0]      req_lock,
  input  logic [64*NUM_REQ-1:0]   req_adr,
  input  logic [64*NUM_REQ-1:0]   req_dat,
  input  logic [8*NUM_REQ-1:0]    req_sel,
  input  logic [16*NUM_REQ-1:0]   req_tga,
  input  logic [16*NUM_REQ-1:0]   req_tgc,
  input  logic [16*NUM_REQ-1:0]   req_tgd,
  output logic [NUM_REQ-1:0]      req_ack,
  output logic [NUM_REQ-1:0]      req_err,
  output logic [NUM_REQ-1:0]      req_rty,
  output logic [63:0]             req_dat_o,
  output logic [15:0]             req_tgd_o,
  output logic [NUM_REQ-1:0]      gnt,
  wb_master_arbiter_if.master     bus
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [WW-1:0] wd_cnt;

  logic          win_vld;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] win_nxt;
  logic          granted;
  logic          resp;
  logic          wd_fire;
  logic          release_gnt;

  // First requester with CYC set, scanning upward from the rotating pointer.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_vld && req_cyc[(int'(ptr) + k) % NUM_REQ]) begin
        win_vld = 1'b1;
        win_idx = PW'((int'(ptr) + k) % NUM_REQ);
      end
    end
    win_nxt = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  end

  assign granted = (state == ST_GRANT);

  always_comb begin
    bus.ADR_O  = '0;
    bus.DAT_O  = '0;
    bus.SEL_O  = '0;
    bus.TGA_O  = '0;
    bus.TGC_O  = '0;
    bus.TGD_O  = '0;
    bus.CYC_O  = 1'b0;
    bus.STB_O  = 1'b0;
    bus.WE_O   = 1'b0;
    bus.LOCK_O = 1'b0;
    if (granted) begin
      bus.ADR_O  = req_adr[64*gidx +: 64];
      bus.DAT_O  = req_dat[64*gidx +: 64];
      bus.SEL_O  = req_sel[8*gidx +: 8];
      bus.TGA_O  = req_tga[16*gidx +: 16];
      bus.TGC_O  = req_tgc[16*gidx +: 16];
      bus.TGD_O  = req_tgd[16*gidx +: 16];
      bus.CYC_O  = req_cyc[gidx];
      bus.STB_O  = req_stb[gidx];
      bus.WE_O   = req_we[gidx];
      bus.LOCK_O = req_lock[gidx];
    end
  end

  assign resp        = bus.ACK_I | bus.ERR_I | bus.RTY_I;
  // Any bus response in the expiry cycle takes precedence over the watchdog error.
  assign wd_fire     = (TIMEOUT != 0) && bus.STB_O && !resp && (wd_cnt == WD_LAST);
  assign release_gnt = wd_fire || (!req_cyc[gidx] && !req_lock[gidx]);

  assign req_ack   = {NUM_REQ{bus.ACK_I}} & gnt & req_stb;
  assign req_err   = {NUM_REQ{bus.ERR_I | wd_fire}} & gnt & req_stb;
  assign req_rty   = {NUM_REQ{bus.RTY_I}} & gnt & req_stb;
  assign req_dat_o = bus.DAT_I;
  assign req_tgd_o = bus.TGD_I;

  always_ff @(posedge clk) begin
    if (RST_I) begin
      state  <= ST_IDLE;
      gnt    <= '0;
      ptr    <= '0;
      gidx   <= '0;
      wd_cnt <= '0;
    end else if (state == ST_IDLE) begin
      wd_cnt <= '0;
      if (win_vld) begin
        state <= ST_GRANT;
        gidx  <= win_idx;
        gnt   <= NUM_REQ'(1) << win_idx;
        ptr   <= win_nxt;
      end
    end else begin
      if (release_gnt) begin
        state  <= ST_IDLE;
        gnt    <= '0;
        wd_cnt <= '0;
      end else if (bus.STB_O && !resp) begin
        wd_cnt <= wd_cnt + 1'b1;
      end else begin
        wd_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Bench for wb_master_arbiter: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a transaction-level ownership model.
module tb_wb_master_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic RST_I;
  always #5 clk = ~clk;

  logic [N-1:0]    req_cyc, req_stb, req_we, req_lock;
  logic [64*N-1:0] req_adr, req_dat;
  logic [8*N-1:0]  req_sel;
  logic [16*N-1:0] req_tga, req_tgc, req_tgd;
  logic [N-1:0]    req_ack, req_err, req_rty, gnt;
  logic [63:0]     req_dat_o;
  logic [15:0]     req_tgd_o;

  wb_master_arbiter_if bus();

  wb_master_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .RST_I(RST_I),
    .req_cyc(req_cyc), .req_stb(req_stb), .req_we(req_we), .req_lock(req_lock),
    .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
    .req_tga(req_tga), .req_tgc(req_tgc), .req_tgd(req_tgd),
    .req_ack(req_ack), .req_err(req_err), .req_rty(req_rty),
    .req_dat_o(req_dat_o), .req_tgd_o(req_tgd_o), .gnt(gnt),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: which requester owns the bus (-1 = nobody), where the rotation starts, stall length.
  int owner = -1, rr = 0, waited = 0;
  int n_owner, n_rr, n_wait;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_cycle();
    logic [N-1:0] eg, ea, ee, er;
    logic [63:0]  eadr, edat;
    logic [7:0]   esel;
    logic [15:0]  etga, etgc, etgd;
    logic         ecyc, estb, ewe, elock;
    bit busy, any_resp, expire;
    busy     = (owner >= 0);
    any_resp = bus.ACK_I || bus.ERR_I || bus.RTY_I;
    expire   = busy && req_stb[owner] && !any_resp && (waited == TO - 1);
    eg = '0; ea = '0; ee = '0; er = '0;
    eadr = '0; edat = '0; esel = '0; etga = '0; etgc = '0; etgd = '0;
    ecyc = 1'b0; estb = 1'b0; ewe = 1'b0; elock = 1'b0;
    if (busy) begin
      eg[owner] = 1'b1;
      eadr = req_adr[64*owner +: 64];
      edat = req_dat[64*owner +: 64];
      esel = req_sel[8*owner +: 8];
      etga = req_tga[16*owner +: 16];
      etgc = req_tgc[16*owner +: 16];
      etgd = req_tgd[16*owner +: 16];
      ecyc = req_cyc[owner]; estb = req_stb[owner]; ewe = req_we[owner]; elock = req_lock[owner];
      ea[owner] = req_stb[owner] && bus.ACK_I;
      ee[owner] = req_stb[owner] && (bus.ERR_I || expire);
      er[owner] = req_stb[owner] && bus.RTY_I;
    end
    chk("m_gnt", gnt, eg);
    chk("m_ack", req_ack, ea);
    chk("m_err", req_err, ee);
    chk("m_rty", req_rty, er);
    chk("m_cyc", bus.CYC_O, ecyc);
    chk("m_stb", bus.STB_O, estb);
    chk("m_we", bus.WE_O, ewe);
    chk("m_lock", bus.LOCK_O, elock);
    chk("m_adr", bus.ADR_O, eadr);
    chk("m_dat", bus.DAT_O, edat);
    chk("m_sel", bus.SEL_O, esel);
    chk("m_tga", bus.TGA_O, etga);
    chk("m_tgc", bus.TGC_O, etgc);
    chk("m_tgd", bus.TGD_O, etgd);
    chk("m_rdat", req_dat_o, bus.DAT_I);
    chk("m_rtgd", req_tgd_o, bus.TGD_I);

    n_owner = owner; n_rr = rr; n_wait = waited;
    if (RST_I) begin
      n_owner = -1; n_rr = 0; n_wait = 0;
    end else if (!busy) begin
      n_wait = 0;
      for (int k = 0; k < N; k++) begin
        if (n_owner < 0 && req_cyc[(rr + k) % N]) begin
          n_owner = (rr + k) % N;
          n_rr    = (n_owner + 1) % N;
        end
      end
    end else if (expire || (!req_cyc[owner] && !req_lock[owner])) begin
      n_owner = -1; n_wait = 0;
    end else begin
      n_wait = (req_stb[owner] && !any_resp) ? waited + 1 : 0;
    end
  endtask

  // Inputs are already driven (post-edge); check this cycle, then advance across one edge.
  task automatic step();
    #1;
    model_cycle();
    @(posedge clk);
    #1;
    owner = n_owner; rr = n_rr; waited = n_wait;
  endtask

  task automatic clear_inputs();
    req_cyc = '0; req_stb = '0; req_we = '0; req_lock = '0;
    req_adr = '0; req_dat = '0; req_sel = '0;
    req_tga = '0; req_tgc = '0; req_tgd = '0;
    bus.ACK_I = 1'b0; bus.ERR_I = 1'b0; bus.RTY_I = 1'b0;
    bus.DAT_I = '0; bus.TGD_I = '0;
  endtask

  task automatic pulse_reset();
    clear_inputs();
    RST_I = 1'b1;
    step();
    RST_I = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [N-1:0] cur, prev;
    int order[$];
    int exp_order[5];
    int idx;
    bit quiet;

    clear_inputs();
    RST_I = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    RST_I = 1'b0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_cyc", bus.CYC_O, 0);
    chk("rst_ack", req_ack, 0);
    chk("rst_adr", bus.ADR_O, 0);

    // Single write from requester 0; a non-granted STB must not see the ACK.
    req_cyc[0] = 1'b1; req_stb[0] = 1'b1; req_we[0] = 1'b1; req_sel[7:0] = 8'hFF;
    req_adr[63:0] = 64'h1000; req_dat[63:0] = 64'hDEADBEEF;
    #1 chk("w_gnt_lat", gnt, 0);
    step();
    #1;
    chk("w_gnt", gnt, 4'b0001);
    chk("w_adr", bus.ADR_O, 64'h1000);
    chk("w_dat", bus.DAT_O, 64'hDEADBEEF);
    chk("w_cyc", bus.CYC_O, 1);
    chk("w_we", bus.WE_O, 1);
    bus.ACK_I = 1'b1; req_stb[2] = 1'b1;
    #1;
    chk("w_ack", req_ack, 4'b0001);
    chk("w_err", req_err, 0);
    step();
    req_cyc[0] = 1'b0; req_stb[0] = 1'b0; req_stb[2] = 1'b0; bus.ACK_I = 1'b0;
    step();
    #1;
    chk("w_rel_gnt", gnt, 0);
    chk("w_rel_adr", bus.ADR_O, 0);

    // Round robin: every requester requests, each leaves after one transfer.
    pulse_reset();
    bus.ACK_I = 1'b1;
    prev = '0;
    exp_order = '{0, 1, 2, 3, 0};
    for (int c = 0; c < 60 && order.size() < 5; c++) begin
      cur = gnt;
      if (cur != 0 && prev == 0) begin
        idx = -1;
        for (int i = 0; i < N; i++) if (cur[i]) idx = i;
        order.push_back(idx);
      end
      if (cur != 0 && cur == prev) begin
        req_cyc = ~cur; req_stb = ~cur;
      end else begin
        req_cyc = '1; req_stb = '1;
      end
      prev = cur;
      step();
    end
    chk("rr_count", order.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < order.size()) chk($sformatf("rr_order_%0d", i), order[i], exp_order[i]);

    // LOCK holds requester 1 across two CYC frames while requester 2 waits.
    pulse_reset();
    req_cyc = 4'b0110; req_lock[1] = 1'b1;
    step();
    #1;
    chk("lk_gnt0", gnt, 4'b0010);
    chk("lk_lock", bus.LOCK_O, 1);
    for (int s = 0; s < 6; s++) begin
      req_cyc[1] = (s == 0 || s == 1 || s == 3 || s == 4);
      step();
      #1 chk($sformatf("lk_hold_%0d", s), gnt, 4'b0010);
    end
    req_cyc[1] = 1'b0; req_lock[1] = 1'b0;
    step();
    #1 chk("lk_rel", gnt, 0);
    step();
    #1 chk("lk_next", gnt, 4'b0100);

    // Watchdog: no response, ERR on the 8th stalled STB cycle, then the other requester.
    pulse_reset();
    req_cyc = 4'b1010; req_stb = 4'b1010;
    step();
    for (int s = 1; s <= TO; s++) begin
      #1 chk($sformatf("to_err_%0d", s), req_err, (s == TO) ? 4'b0010 : 4'b0000);
      step();
    end
    #1;
    chk("to_gnt_idle", gnt, 0);
    chk("to_cyc_idle", bus.CYC_O, 0);
    step();
    #1 chk("to_next", gnt, 4'b1000);

    // Reset in the middle of requester 3's burst; afterwards requester 0 wins from pointer 0.
    pulse_reset();
    req_cyc = 4'b1000;
    step();
    step();
    #1 chk("rb_gnt3", gnt, 4'b1000);
    req_cyc = 4'b1001; RST_I = 1'b1;
    step();
    RST_I = 1'b0;
    #1;
    chk("rb_gnt_rst", gnt, 0);
    chk("rb_cyc_rst", bus.CYC_O, 0);
    step();
    #1 chk("rb_gnt0", gnt, 4'b0001);

    // Randomized traffic, alternating responsive and stalling slave phases.
    for (int c = 0; c < 3000; c++) begin
      quiet = ((c / 150) % 2) == 1;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(5) == 0) req_cyc[i] = ~req_cyc[i];
        req_stb[i]  = req_cyc[i] & 1'($urandom_range(1));
        req_we[i]   = 1'($urandom_range(1));
        req_lock[i] = req_cyc[i] & ($urandom_range(7) == 0);
        req_adr[64*i +: 64] = {$urandom, $urandom};
        req_dat[64*i +: 64] = {$urandom, $urandom};
        req_sel[8*i +: 8]   = 8'($urandom);
        req_tga[16*i +: 16] = 16'($urandom);
        req_tgc[16*i +: 16] = 16'($urandom);
        req_tgd[16*i +: 16] = 16'($urandom);
      end
      bus.ACK_I = quiet ? ($urandom_range(31) == 0) : 1'($urandom_range(1));
      bus.ERR_I = quiet ? ($urandom_range(31) == 0) : ($urandom_range(9) == 0);
      bus.RTY_I = quiet ? ($urandom_range(31) == 0) : ($urandom_range(11) == 0);
      bus.DAT_I = {$urandom, $urandom};
      bus.TGD_I = 16'($urandom);
      RST_I = ($urandom_range(249) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
